eb1_trace_packer: RTL and testbench
===================================

// Module: eb1_trace_packer
// PURPOSE
//  Consumes the per-retire eb1_trace_pkt_t from the core trace port and buffers it in a small FIFO.
//  Serialises each packet into 32-bit beats on a valid/ready stream toward the debug/trace sink.
//  Overflow drops whole packets and reports the drop count in the next accepted header.
//  Sits between the core trace outputs and the SoC trace export/capture logic.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of 2, >=2); each entry holds one packet + header fields
// PORTS
//  clk            in   1    core clock; the only clock
//  rst_l          in   1    asynchronous, active-low reset
//  trace_en       in   1    1 = capture enabled; 0 = input ignored, FIFO keeps draining
//  trace_pkt      in   eb1_trace_pkt_t  retire trace; sampled when trace_rv_i_valid_ip=1
//  tr_data        out  32   current beat
//  tr_valid       out  1    beat valid
//  tr_last        out  1    final beat of the packet
//  tr_ready       in   1    sink accepts the beat when tr_valid&tr_ready
//  tr_fifo_full   out  1    count==DEPTH
//  tr_drop_pend   out  1    drop counter nonzero (drops not yet reported)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, seq=0, drop_cnt=0, FSM=IDLE; asserting mid-packet aborts it at once.
//  Capture: trace_en & trace_rv_i_valid_ip & count<DEPTH -> push {pkt, seq, drop_cnt}; seq+=1 (16b, wraps);
//    drop_cnt cleared the same cycle.
//  Overflow: the capture condition with count==DEPTH drops the packet. drop_cnt+=1, saturating at 255; seq unchanged.
//  No same-cycle bypass: a pop in the cycle of a push while full does not make room; the push drops.
//  Push and pop in the same cycle when not full: count is unchanged.
//  Beats, in order: HDR, ADDR, INSN, then TVAL only if exception|interrupt.
//    HDR[31]=1, [30]=exception, [29]=interrupt, [28:24]=ecause, [23:16]=drop_cnt snapshot, [15:0]=seq.
//    ADDR=trace_rv_i_address_ip. INSN=trace_rv_i_insn_ip. TVAL=trace_rv_i_tval_ip.
//  tr_last=1 on INSN for normal packets and on TVAL for exception/interrupt packets.
//  FSM: IDLE -> HDR when FIFO non-empty (registered; first beat one cycle after push).
//    Sequence HDR -> ADDR -> INSN -> {TVAL} -> HDR or IDLE.
//    Each state advances only on tr_valid&tr_ready.
//    On the last beat the entry pops; next state is HDR if count after pop >0, else IDLE (no bubble between packets).
//  Stream rule: while tr_valid&!tr_ready, tr_data/tr_last are held stable; tr_valid never drops without a handshake.
//  tr_valid=1 in every state except IDLE; outputs driven from the FIFO head + FSM state (head is stable while non-empty).
//  trace_en=0: no push and no drop counting; queued packets still drain completely.
// STRUCTURE
//  Add to eb1_pkg: eb1_trace_hdr_t (packed {sync, exc, intr, ecause[4:0], drop[7:0], seq[15:0]}).
//  Add to eb1_pkg: eb1_trace_beat_e enum {IDLE, HDR, ADDR, INSN, TVAL}.
//  Sub-module eb1_trace_fifo: generic DEPTH x W register FIFO, wr/rd pointers + count, full/empty, async rst_l.
//  Top holds the seq/drop counters, the header build and the serialiser FSM.
// TESTING
//  1 Normal packet (addr=0x8000_0100, insn=0x0000_0013, no exc) with tr_ready=1:
//    beats = 0x8000_0000 / 0x8000_0100 / 0x0000_0013; tr_last on beat 3; first beat 1 cycle after push.
//  2 Exception packet (ecause=2, tval=0xDEAD_BEEF):
//    4 beats; HDR=0xC200_0000|seq; last beat 0xDEAD_BEEF with tr_last=1.
//  3 tr_ready=0, 6 packets pushed back-to-back, DEPTH=4:
//    tr_fifo_full=1, 2 drops, tr_drop_pend=1.
//    After tr_ready=1, only the next captured packet's HDR[23:16]=2; seq values are contiguous 0..4.
//  4 Backpressure: toggle tr_ready randomly per cycle:
//    tr_data/tr_last stable whenever valid&!ready; 50 packets arrive intact and in order.
//  5 Two packets pushed on consecutive cycles:
//    second packet's HDR follows the first packet's tr_last beat with no idle cycle.
//  6 Assert rst_l low during the ADDR beat:
//    tr_valid=0 immediately; after release no residual beats; next packet has seq=0.
//  Also: 300 overflow drops -> reported drop=255 (saturated); seq wrap 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/eb1_pkg.sv
// Trace packer types: core retire packet, packed beat header, FIFO entry and serialiser states.
// trace_entry() builds the stored FIFO word from a retire packet plus the live seq/drop counters.
package eb1_pkg;

    typedef struct packed {
        logic        trace_rv_i_valid_ip;
        logic [31:0] trace_rv_i_insn_ip;
        logic [31:0] trace_rv_i_address_ip;
        logic        trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic        trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } eb1_trace_pkt_t;

    typedef struct packed {
        logic        sync;
        logic        exc;
        logic        intr;
        logic [4:0]  ecause;
        logic [7:0]  drop;
        logic [15:0] seq;
    } eb1_trace_hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ADDR,
        INSN,
        TVAL
    } eb1_trace_beat_e;

    typedef struct packed {
        eb1_trace_hdr_t hdr;
        logic [31:0]    addr;
        logic [31:0]    insn;
        logic [31:0]    tval;
    } eb1_trace_entry_t;

    localparam int TRACE_ENTRY_W = $bits(eb1_trace_entry_t);

    function automatic eb1_trace_entry_t trace_entry(input eb1_trace_pkt_t pkt,
                                                     input logic [7:0]     drop,
                                                     input logic [15:0]    seq);
        eb1_trace_entry_t e;
        e.hdr.sync   = 1'b1;
        e.hdr.exc    = pkt.trace_rv_i_exception_ip;
        e.hdr.intr   = pkt.trace_rv_i_interrupt_ip;
        e.hdr.ecause = pkt.trace_rv_i_ecause_ip;
        e.hdr.drop   = drop;
        e.hdr.seq    = seq;
        e.addr       = pkt.trace_rv_i_address_ip;
        e.insn       = pkt.trace_rv_i_insn_ip;
        e.tval       = pkt.trace_rv_i_tval_ip;
        return e;
    endfunction

endpackage

// File: rtl/eb1_trace_fifo.sv
// Generic DEPTH x W register FIFO; write is ignored when full, read when empty.
// rd_data shows the head combinationally and only moves on a read.
module eb1_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w_wr    = wr_en & ~full;
    assign w_rd    = rd_en & ~empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/eb1_trace_packer.sv
// Buffers retire trace packets and serialises each as HDR/ADDR/INSN[/TVAL] 32-bit beats.
// First beat the cycle after capture; beats hold while tr_ready=0; overflow drops whole packets.
module eb1_trace_packer
    import eb1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           trace_en,
    input  eb1_trace_pkt_t trace_pkt,
    output logic [31:0]    tr_data,
    output logic           tr_valid,
    output logic           tr_last,
    input  logic           tr_ready,
    output logic           tr_fifo_full,
    output logic           tr_drop_pend
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    eb1_trace_beat_e   r_state;
    eb1_trace_beat_e   w_state_nxt;
    logic [15:0]       r_seq;
    logic [7:0]        r_drop_cnt;

    logic              w_cap;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_more;
    logic              w_has_tval;
    logic [CNT_W-1:0]  w_count;
    eb1_trace_entry_t  w_wr_entry;
    eb1_trace_entry_t  w_head;

    assign w_cap      = trace_en & trace_pkt.trace_rv_i_valid_ip;
    assign w_push     = w_cap & ~w_full;
    assign w_drop     = w_cap & w_full;
    assign w_wr_entry = trace_entry(trace_pkt, r_drop_cnt, r_seq);

    eb1_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (TRACE_ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_l   (rst_l),
        .wr_en   (w_push),
        .wr_data (w_wr_entry),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign tr_fifo_full = w_full;
    assign tr_drop_pend = (r_drop_cnt != 8'd0);
    assign w_has_tval   = w_head.hdr.exc | w_head.hdr.intr;
    // Entries left after the pop, counting a same-cycle push, decide HDR vs IDLE.
    assign w_more       = (w_count > CNT_W'(1)) | w_push;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_seq      <= '0;
            r_drop_cnt <= '0;
        end else if (w_push) begin
            r_seq      <= r_seq + 16'd1;
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        tr_valid    = 1'b0;
        tr_last     = 1'b0;
        tr_data     = '0;
        case (r_state)
            IDLE: begin
                if (!w_empty || w_push) begin
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                tr_valid = 1'b1;
                tr_data  = w_head.hdr;
                if (tr_ready) begin
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                tr_valid = 1'b1;
                tr_data  = w_head.addr;
                if (tr_ready) begin
                    w_state_nxt = INSN;
                end
            end
            INSN: begin
                tr_valid = 1'b1;
                tr_data  = w_head.insn;
                tr_last  = ~w_has_tval;
                if (tr_ready) begin
                    if (w_has_tval) begin
                        w_state_nxt = TVAL;
                    end else begin
                        w_pop       = 1'b1;
                        w_state_nxt = w_more ? HDR : IDLE;
                    end
                end
            end
            TVAL: begin
                tr_valid = 1'b1;
                tr_data  = w_head.tval;
                tr_last  = 1'b1;
                if (tr_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = w_more ? HDR : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_eb1_trace_packer.sv
// Directed bench for eb1_trace_packer: beat contents, timing, overflow/drop reporting, reset abort.
module tb_eb1_trace_packer;
    import eb1_pkg::*;

    logic           clk;
    logic           rst_l;
    logic           trace_en;
    eb1_trace_pkt_t trace_pkt;
    logic [31:0]    tr_data;
    logic           tr_valid;
    logic           tr_last;
    logic           tr_ready;
    logic           tr_fifo_full;
    logic           tr_drop_pend;

    int          n_tests;
    int          n_fail;
    int          cyc;
    logic [32:0] got_q[$];
    int          got_cyc[$];
    logic [32:0] exp_q[$];
    logic        prev_stall;
    logic [33:0] prev_beat;
    logic        rnd_on;

    eb1_trace_packer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .trace_en     (trace_en),
        .trace_pkt    (trace_pkt),
        .tr_data      (tr_data),
        .tr_valid     (tr_valid),
        .tr_last      (tr_last),
        .tr_ready     (tr_ready),
        .tr_fifo_full (tr_fifo_full),
        .tr_drop_pend (tr_drop_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beat monitor: records handshakes and checks that a stalled beat is held.
    always @(negedge clk) begin
        if (!rst_l) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {tr_valid, tr_last, tr_data}, prev_beat);
            if (tr_valid && tr_ready) begin
                got_q.push_back({tr_last, tr_data});
                got_cyc.push_back(cyc);
            end
            prev_stall = tr_valid && !tr_ready;
            prev_beat  = {tr_valid, tr_last, tr_data};
        end
    end

    function automatic logic [31:0] hdr(input logic exc, input logic intr, input logic [4:0] ec,
                                        input logic [7:0] drop, input logic [15:0] seq);
        return {1'b1, exc, intr, ec, drop, seq};
    endfunction

    task automatic exp_pkt(input logic [31:0] h, input logic [31:0] addr, input logic [31:0] insn,
                           input logic tv, input logic [31:0] tval);
        exp_q.push_back({1'b0, h});
        exp_q.push_back({1'b0, addr});
        exp_q.push_back({~tv, insn});
        if (tv) exp_q.push_back({1'b1, tval});
    endtask

    task automatic set_pkt(input logic [31:0] addr, input logic [31:0] insn, input logic exc,
                           input logic intr, input logic [4:0] ec, input logic [31:0] tval);
        trace_pkt.trace_rv_i_valid_ip     = 1'b1;
        trace_pkt.trace_rv_i_address_ip   = addr;
        trace_pkt.trace_rv_i_insn_ip      = insn;
        trace_pkt.trace_rv_i_exception_ip = exc;
        trace_pkt.trace_rv_i_interrupt_ip = intr;
        trace_pkt.trace_rv_i_ecause_ip    = ec;
        trace_pkt.trace_rv_i_tval_ip      = tval;
    endtask

    task automatic send(input logic [31:0] addr, input logic [31:0] insn, input logic exc,
                        input logic intr, input logic [4:0] ec, input logic [31:0] tval);
        set_pkt(addr, insn, exc, intr, ec, tval);
        @(posedge clk); #1;
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
    endtask

    task automatic compare_all(input string tag, input int budget);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("%s beat count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        @(posedge clk); #1;
        rst_l = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        trace_en = 1'b1; tr_ready = 1'b1; trace_pkt = '0; rnd_on = 1'b0;
        prev_stall = 1'b0; prev_beat = '0;
        rst_l = 1'b1;
        #1 rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", tr_valid, 0);
        chk("reset last", tr_last, 0);
        chk("reset data", tr_data, 0);
        chk("reset full", tr_fifo_full, 0);
        chk("reset drop_pend", tr_drop_pend, 0);
        rst_l = 1'b1;
        @(posedge clk); #1;

        // 1: normal packet, first beat the cycle after capture
        set_pkt(32'h8000_0100, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("t1 valid before push", tr_valid, 0);
        @(posedge clk); #1;
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
        chk("t1 first valid", tr_valid, 1);
        chk("t1 first data", tr_data, 32'h8000_0000);
        exp_pkt(32'h8000_0000, 32'h8000_0100, 32'h0000_0013, 1'b0, 32'h0);
        compare_all("t1", 20);

        // 2: exception packet, seq=1
        send(32'h8000_0200, 32'h0000_0073, 1'b1, 1'b0, 5'd2, 32'hDEAD_BEEF);
        exp_pkt(32'hC200_0001, 32'h8000_0200, 32'h0000_0073, 1'b1, 32'hDEAD_BEEF);
        compare_all("t2", 20);

        // 3: overflow with sink stalled; trace_en=0 for the tail neither pushes nor counts
        do_reset();
        tr_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            trace_en = (i < 6);
            set_pkt(32'h1000_0000 + 32'(i * 16), 32'h100 + 32'(i), 1'b0, 1'b0, 5'd0, 32'h0);
            @(posedge clk); #1;
        end
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
        chk("t3 full", tr_fifo_full, 1);
        chk("t3 drop_pend", tr_drop_pend, 1);
        chk("t3 stalled hdr", tr_data, 32'h8000_0000);
        for (int i = 0; i < 4; i++)
            exp_pkt(hdr(1'b0, 1'b0, 5'd0, 8'd0, 16'(i)), 32'h1000_0000 + 32'(i * 16),
                    32'h100 + 32'(i), 1'b0, 32'h0);
        tr_ready = 1'b1;
        compare_all("t3 drain", 100);
        trace_en = 1'b1;
        send(32'h2000_0000, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t3 drop cleared", tr_drop_pend, 0);
        exp_pkt(32'h8002_0004, 32'h2000_0000, 32'h200, 1'b0, 32'h0);
        compare_all("t3 report", 20);
        send(32'h2000_0010, 32'h201, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_pkt(32'h8000_0005, 32'h2000_0010, 32'h201, 1'b0, 32'h0);
        compare_all("t3 after", 20);

        // 4: random backpressure, 50 packets, never overflowing
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    int w;
                    logic ex, it;
                    w = 0;
                    while (tr_fifo_full && w < 200) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    chk($sformatf("t4 room %0d", i), w < 200, 1);
                    ex = (i % 5 == 0);
                    it = (i % 7 == 3);
                    set_pkt(32'h4000_0000 + 32'(i * 4), 32'h4400_0000 + 32'(i), ex, it,
                            5'(i % 32), 32'hF000_0000 + 32'(i));
                    exp_pkt(hdr(ex, it, 5'(i % 32), 8'd0, 16'(6 + i)), 32'h4000_0000 + 32'(i * 4),
                            32'h4400_0000 + 32'(i), ex | it, 32'hF000_0000 + 32'(i));
                    @(posedge clk); #1;
                    trace_pkt.trace_rv_i_valid_ip = 1'b0;
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    tr_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        tr_ready = 1'b1;
        compare_all("t4", 600);

        // 5: back-to-back packets stream with no idle cycle between them
        set_pkt(32'h3000_0000, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        set_pkt(32'h3000_0010, 32'h301, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
        exp_pkt(32'h8000_0038, 32'h3000_0000, 32'h300, 1'b0, 32'h0);
        exp_pkt(32'h8000_0039, 32'h3000_0010, 32'h301, 1'b0, 32'h0);
        for (int n = 0; n < 20 && got_q.size() < 6; n++) begin
            @(posedge clk); #1;
        end
        if (got_cyc.size() >= 4) chk("t5 gap", got_cyc[3] - got_cyc[2], 1);
        else chk("t5 beats seen", got_cyc.size(), 4);
        compare_all("t5", 20);

        // 6: reset during the ADDR beat aborts the packet and restarts seq
        send(32'h5000_0000, 32'h500, 1'b0, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        chk("t6 addr beat", tr_data, 32'h5000_0000);
        #1 rst_l = 1'b0;
        #1;
        chk("t6 valid in reset", tr_valid, 0);
        chk("t6 data in reset", tr_data, 0);
        @(posedge clk); #1;
        rst_l = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6 residual beats", got_q.size(), 1);
        if (got_q.size() > 0) chk("t6 aborted hdr", got_q[0], {1'b0, 32'h8000_003A});
        got_q.delete();
        got_cyc.delete();
        send(32'h6000_0000, 32'h600, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_pkt(32'h8000_0000, 32'h6000_0000, 32'h600, 1'b0, 32'h0);
        compare_all("t6", 20);

        // 7: 300 drops saturate the reported count at 255
        tr_ready = 1'b0;
        for (int i = 0; i < 304; i++) begin
            set_pkt(32'h7000_0000 + 32'(i * 16), 32'h700 + 32'(i), 1'b0, 1'b0, 5'd0, 32'h0);
            @(posedge clk); #1;
        end
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
        chk("t7 full", tr_fifo_full, 1);
        chk("t7 drop_pend", tr_drop_pend, 1);
        for (int i = 0; i < 4; i++)
            exp_pkt(hdr(1'b0, 1'b0, 5'd0, 8'd0, 16'(1 + i)), 32'h7000_0000 + 32'(i * 16),
                    32'h700 + 32'(i), 1'b0, 32'h0);
        tr_ready = 1'b1;
        compare_all("t7 drain", 100);
        send(32'h7F00_0000, 32'h7FF, 1'b0, 1'b0, 5'd0, 32'h0);
        exp_pkt(32'h80FF_0005, 32'h7F00_0000, 32'h7FF, 1'b0, 32'h0);
        compare_all("t7 report", 20);

        // 8: capture disabled ignores the input
        trace_en = 1'b0;
        send(32'h9000_0000, 32'h900, 1'b0, 1'b0, 5'd0, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("t8 no beats", got_q.size(), 0);
        chk("t8 valid", tr_valid, 0);
        trace_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
